// File: rtl/pp_gen_5bit_if.sv
// pp_gen_5bit_if: operand/row-set handshake bundle for pp_gen_5bit.
// The slave modport is the generator side; the master modport drives operands and consumes rows.
interface pp_gen_5bit_if;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] a;
  logic [4:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] pp0, pp1, pp2, pp3, pp4;
  logic       pp_ci;
  logic [7:0] ops_done;
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, pp0, pp1, pp2, pp3, pp4, pp_ci, ops_done
  );
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, pp0, pp1, pp2, pp3, pp4, pp_ci, ops_done
  );
endinterface

// File: rtl/pp_gen_5bit.sv
// pp_gen_5bit: 5x5 partial-product row generator behind a 2-entry skid buffer.
// Define PP_SIGNED_EN for two's-complement operands (inverted top row plus carry-in).
module pp_gen_5bit (
  input  logic         clk,
  input  logic         rst_n,
  pp_gen_5bit_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t          r_state, w_next;
  logic            r_in_ready, r_out_valid;
  logic [4:0][9:0] r_out_pp, r_skid_pp, w_pp;
  logic            r_out_ci, r_skid_ci, w_ci;
  logic [7:0]      r_ops;
  logic [9:0]      w_a_ext;
  logic            w_in_xfer, w_out_xfer, w_load_out, w_load_skid, w_from_skid;
  assign w_in_xfer  = bus.in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & bus.out_ready;
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.pp0 = r_out_pp[0];
  assign bus.pp1 = r_out_pp[1];
  assign bus.pp2 = r_out_pp[2];
  assign bus.pp3 = r_out_pp[3];
  assign bus.pp4 = r_out_pp[4];
  assign bus.pp_ci    = r_out_ci;
  assign bus.ops_done = r_ops;
  always_comb begin
`ifdef PP_SIGNED_EN
    w_a_ext = {{5{bus.a[4]}}, bus.a};
    w_ci    = bus.b[4];
`else
    w_a_ext = {5'b0, bus.a};
    w_ci    = 1'b0;
`endif
    for (int i = 0; i < 5; i++) w_pp[i] = bus.b[i] ? w_a_ext << i : 10'd0;
`ifdef PP_SIGNED_EN
    // negative-weight top row: ~x here plus pp_ci gives -x
    w_pp[4] = bus.b[4] ? ~(w_a_ext << 4) : 10'd0;
`endif
  end
  always_comb begin
    w_next      = r_state;
    w_load_out  = 1'b0;
    w_load_skid = 1'b0;
    w_from_skid = 1'b0;
    case (r_state)
      EMPTY: if (w_in_xfer) begin
        w_next     = ONE;
        w_load_out = 1'b1;
      end
      ONE: begin
        w_next      = w_in_xfer ? (w_out_xfer ? ONE : FULL) : (w_out_xfer ? EMPTY : ONE);
        w_load_out  = w_in_xfer & w_out_xfer;
        w_load_skid = w_in_xfer & ~w_out_xfer;
      end
      FULL: if (w_out_xfer) begin
        w_next      = ONE;
        w_load_out  = 1'b1;
        w_from_skid = 1'b1;
      end
      default: w_next = EMPTY;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_pp    <= '0;
      r_out_ci    <= 1'b0;
      r_skid_pp   <= '0;
      r_skid_ci   <= 1'b0;
      r_ops       <= 8'd0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= w_next != FULL;
      r_out_valid <= w_next != EMPTY;
      if (w_load_out) begin
        r_out_pp <= w_from_skid ? r_skid_pp : w_pp;
        r_out_ci <= w_from_skid ? r_skid_ci : w_ci;
      end
      if (w_load_skid) begin
        r_skid_pp <= w_pp;
        r_skid_ci <= w_ci;
      end
      if (w_out_xfer) r_ops <= r_ops + 8'd1;
    end
  end
endmodule

// File: tb/tb_pp_gen_5bit.sv
// tb_pp_gen_5bit: randomized bench for pp_gen_5bit against a queue-based reference of row sets.
// Build with PP_SIGNED_EN to check the signed rows.
module tb_pp_gen_5bit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  pp_gen_5bit_if bus();
  pp_gen_5bit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_vec = 0;
  int n_err = 0;
  int ops = 0;
  logic [50:0] q[$];
  int pq[$];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int sval(input logic [4:0] v);
`ifdef PP_SIGNED_EN
    return v[4] ? int'(v) - 32 : int'(v);
`else
    return int'(v);
`endif
  endfunction
  function automatic logic [50:0] ref_rows(input logic [4:0] a, input logic [4:0] b);
    logic [50:0] r;
    int x;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      x = b[i] ? sval(a) * (1 << i) : 0;
`ifdef PP_SIGNED_EN
      if (i == 4 && b[4]) begin
        x = ~x;
        r[50] = 1'b1;
      end
`endif
      r[i*10 +: 10] = 10'(x & 1023);
    end
    return r;
  endfunction
  task automatic cycle();
    bit in_x, out_x;
    logic [4:0] ca, cb;
    in_x  = bus.in_valid && q.size() < 2;
    out_x = bus.out_ready && q.size() > 0;
    ca = bus.a;
    cb = bus.b;
    @(posedge clk);
    if (out_x) begin
      void'(q.pop_front());
      void'(pq.pop_front());
      ops++;
    end
    if (in_x) begin
      q.push_back(ref_rows(ca, cb));
      pq.push_back((sval(ca) * sval(cb)) & 1023);
    end
    #1;
    chk("in_ready", bus.in_ready, q.size() < 2);
    chk("out_valid", bus.out_valid, q.size() > 0);
    chk("ops_done", bus.ops_done, ops % 256);
    if (q.size() > 0) begin
      chk("rows", {bus.pp_ci, bus.pp4, bus.pp3, bus.pp2, bus.pp1, bus.pp0}, q[0]);
      chk("sum", (bus.pp0 + bus.pp1 + bus.pp2 + bus.pp3 + bus.pp4 + bus.pp_ci) & 10'h3FF, pq[0]);
    end
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.a = 5'd0;
    bus.b = 5'd0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_rows", {bus.pp_ci, bus.pp4, bus.pp3, bus.pp2, bus.pp1, bus.pp0}, 0);
    chk("rst_ops", bus.ops_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    bus.a = 5'd3;
    bus.b = 5'd5;
    cycle();
    chk("a3b5_pp0", bus.pp0, 10'h003);
    chk("a3b5_pp2", bus.pp2, 10'h00C);
    chk("a3b5_valid", bus.out_valid, 1);
    bus.a = 5'h1F;
    bus.b = 5'h10;
    cycle();
`ifdef PP_SIGNED_EN
    chk("neg1x16_pp4", bus.pp4, 10'h00F);
    chk("neg1x16_ci", bus.pp_ci, 1);
    chk("neg1x16_sum", (bus.pp0 + bus.pp1 + bus.pp2 + bus.pp3 + bus.pp4 + bus.pp_ci) & 10'h3FF, 16);
`else
    chk("31x16_pp4", bus.pp4, 10'h1F0);
    chk("31x16_ci", bus.pp_ci, 0);
    chk("31x16_sum", (bus.pp0 + bus.pp1 + bus.pp2 + bus.pp3 + bus.pp4 + bus.pp_ci) & 10'h3FF, 496);
`endif
    bus.in_valid = 1'b0;
    cycle();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.a = 5'($urandom);
      bus.b = 5'($urandom);
      cycle();
    end
    chk("bp_in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    cycle();
    chk("bp_ready_back", bus.in_ready, 1);
    cycle();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.a = 5'($urandom);
      bus.b = 5'($urandom);
      cycle();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    chk("arst_ops", bus.ops_done, 0);
    chk("arst_rows", {bus.pp_ci, bus.pp4, bus.pp3, bus.pp2, bus.pp1, bus.pp0}, 0);
    q.delete();
    pq.delete();
    ops = 0;
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 257; i++) begin
      bus.a = 5'($urandom);
      bus.b = 5'($urandom);
      cycle();
    end
    bus.in_valid = 1'b0;
    cycle();
    chk("ops_wrap", bus.ops_done, 1);
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = 1'($urandom);
      bus.out_ready = 1'($urandom);
      bus.a = 5'($urandom);
      bus.b = 5'($urandom);
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pp_gen_5bit.md
PP_GEN_5BIT -- requirements
Module: pp_gen_5bit

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 in_valid  input  1  operand pair a/b presented by the producer.
REQ-004 in_ready  output  1  block can accept an operand pair; driven directly from a register.
REQ-005 a  input  5  multiplicand.
REQ-006 b  input  5  multiplier.
REQ-007 out_valid  output  1  pp0..pp4/pp_ci hold a valid row set for the 5-operand 10-bit adder.
REQ-008 out_ready  input  1  the adder stage consumes the current row set.
REQ-009 pp0, pp1, pp2, pp3, pp4  output  10 each  partial-product rows, with pp<i> aligned to weight 2^i.
REQ-010 pp_ci  output  1  carry-in for the adder; nonzero only in signed mode.
REQ-011 ops_done  output  8  count of completed output transfers, wrapping modulo 256.

Function
REQ-012 Input transfer occurs on a cycle with in_valid and in_ready both high; output transfer occurs on a cycle with out_valid and out_ready both high.
REQ-013 The block SHALL be a 2-entry buffer (output register plus skid register) with FSM states EMPTY, ONE and FULL.
REQ-014 EMPTY: input transfer -> ONE, with the row set written to the output register.
REQ-015 ONE: input transfer only -> FULL, with the row set written to the skid register; output transfer only -> EMPTY; both together -> ONE, with the new row set written to the output register.
REQ-016 FULL: output transfer -> ONE, with the skid register moved to the output register; in_ready is low, so no input transfer occurs.
REQ-017 out_valid is high in ONE and FULL; in_ready is high in EMPTY and ONE.
REQ-018 Latency is 1 cycle: the row set of an input transfer at edge N is visible on the outputs after edge N when the buffer was EMPTY.
REQ-019 Back-to-back operation SHALL sustain 1 transfer per cycle while out_ready stays high.
REQ-020 Row sets SHALL leave in acceptance order, with none dropped or duplicated.
REQ-021 Output data SHALL hold stable while out_valid is high and out_ready is low.
REQ-022 Unsigned row rule, for each i: pp<i> = b[i] ? ({5'b0,a} << i) : 0, truncated to 10 bits; pp_ci = 0.
REQ-023 For any operands, the 10-bit sum of all rows plus pp_ci SHALL equal the exact product modulo 2^10.
REQ-024 ops_done increments by 1 on each output transfer; 255 wraps to 0.
REQ-025 Data registers in an invalid entry are don't-care; only out_valid gates their use.

Reset
REQ-026 While rst_n is low: state EMPTY, out_valid 0, in_ready 1, pp0..pp4 = 0, pp_ci 0, ops_done 0.
REQ-027 Reset asserted mid-operation SHALL discard all buffered row sets immediately, without waiting for a clock edge.
REQ-028 The first input transfer is possible on the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro PP_SIGNED_EN: when defined, a and b are two's complement and signed rows are used.
- Signed rows: A_ext = a sign-extended to 10 bits; pp<i> = b[i] ? (A_ext << i) : 0 for i = 0..3.
- Signed rows: pp4 = b[4] ? ~(A_ext << 4) : 0; pp_ci = b[4].
REQ-030 When PP_SIGNED_EN is undefined: unsigned rule of REQ-022 applies, and pp_ci is tied to 0.
REQ-031 Handshake, FSM and counter behaviour SHALL be identical in both builds.

Verification
REQ-032 Unsigned, out_ready=1: a=3, b=5 -> next cycle pp0=0x003, pp1=0, pp2=0x00C, pp3=0, pp4=0, pp_ci=0, out_valid=1.
REQ-033 Unsigned: a=31, b=16 -> pp4=0x1F0, other rows 0, pp_ci=0; row sum = 496.
REQ-034 PP_SIGNED_EN: a=5'h1F (-1), b=5'h10 (-16) -> pp4=0x00F, pp_ci=1, other rows 0; sum = 0x010 (16).
REQ-035 Backpressure: out_ready=0 while offering 3 pairs -> first 2 accepted, in_ready=0 after the second; out_ready=1 -> rows emerge in order, in_ready returns high in the next cycle.
REQ-036 Reset mid-stream: FULL state, rst_n pulsed low between edges -> out_valid=0, in_ready=1, ops_done=0 immediately.
REQ-037 Stream 257 transfers with out_ready=1 -> ops_done=1 after the last transfer, and all 257 random-operand row sums match a*b mod 1024.
